// File: rtl/t1emu_sim_pkg.sv
// Shared simulation-harness types: watchdog FSM states and the status byte
// values polled by the clock generator.
package t1emu_sim_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        FAIL  = 2'd3
    } wd_state_e;

    localparam logic [7:0] WD_RUNNING   = 8'd0;
    localparam logic [7:0] WD_SUCCESS   = 8'd255;
    localparam logic [7:0] WD_RETIRE_TO = 8'd1;
    localparam logic [7:0] WD_GLOBAL_TO = 8'd2;
    localparam logic [7:0] WD_DRAIN_TO  = 8'd3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over enable, reset wins over both.
module sat_counter #(
    parameter int W = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (enable && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/retire_watchdog.sv
// Simulation watchdog: tracks retire activity and completion flags, reports a
// sticky status byte for the clock generator and drives the dump window.
module retire_watchdog
    import t1emu_sim_pkg::*;
#(
    parameter int CNT_W        = 64,
    parameter int DRAIN_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] cfg_timeout,
    input  logic [CNT_W-1:0] cfg_global_timeout,
    input  logic [CNT_W-1:0] cfg_dump_start,
    input  logic [CNT_W-1:0] cfg_dump_end,
    input  logic             retire_valid,
    input  logic             dpi_done,
    input  logic             tb_done,
    output logic [7:0]       status,
    output logic [CNT_W-1:0] cycle,
    output logic             dump_active
);

    wd_state_e        state_reg;
    logic [CNT_W-1:0] cfg_timeout_reg;
    logic [CNT_W-1:0] cfg_global_reg;
    logic [CNT_W-1:0] cfg_start_reg;
    logic [CNT_W-1:0] cfg_end_reg;
    logic             dpi_seen_reg;
    logic             tb_seen_reg;

    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] drain_cnt;
    logic [CNT_W-1:0] cycle_next;
    logic             running;
    logic             in_drain;
    logic             dump_next;
    logic             both_done;
    logic             one_done;
    logic             retire_to;
    logic             global_to;
    logic             drain_to;

    assign running  = (state_reg == RUN) || (state_reg == DRAIN);
    assign in_drain = (state_reg == DRAIN);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (1'b0),
        .enable (running),
        .count  (cycle)
    );

    sat_counter #(.W(CNT_W)) u_idle_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (retire_valid),
        .enable (running),
        .count  (idle_cnt)
    );

    // Held at zero outside DRAIN so it starts from zero on entry.
    sat_counter #(.W(CNT_W)) u_drain_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (!in_drain),
        .enable (in_drain),
        .count  (drain_cnt)
    );

    always_comb begin
        cycle_next = (cycle == {CNT_W{1'b1}}) ? cycle : cycle + CNT_W'(1);
        dump_next  = (cycle_next >= cfg_start_reg) &&
                     ((cfg_end_reg == '0) || (cycle_next < cfg_end_reg));
        both_done  = (dpi_seen_reg | dpi_done) & (tb_seen_reg | tb_done);
        one_done   = dpi_done ^ tb_done;
        // A saturated counter wraps to 0 here, which never matches a nonzero limit.
        retire_to  = (cfg_timeout_reg != '0) && !retire_valid &&
                     ((idle_cnt + CNT_W'(1)) == cfg_timeout_reg);
        global_to  = (cfg_global_reg != '0) &&
                     ((cycle + CNT_W'(1)) == cfg_global_reg);
        drain_to   = in_drain && ((drain_cnt + CNT_W'(1)) == CNT_W'(DRAIN_CYCLES));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg       <= RUN;
            status          <= WD_RUNNING;
            dump_active     <= (cfg_dump_start == '0);
            cfg_timeout_reg <= cfg_timeout;
            cfg_global_reg  <= cfg_global_timeout;
            cfg_start_reg   <= cfg_dump_start;
            cfg_end_reg     <= cfg_dump_end;
            dpi_seen_reg    <= 1'b0;
            tb_seen_reg     <= 1'b0;
        end else if (running) begin
            dump_active  <= dump_next;
            dpi_seen_reg <= dpi_seen_reg | dpi_done;
            tb_seen_reg  <= tb_seen_reg | tb_done;
            if (both_done) begin
                state_reg <= DONE;
                status    <= WD_SUCCESS;
            end else if (retire_to) begin
                state_reg <= FAIL;
                status    <= WD_RETIRE_TO;
            end else if (global_to) begin
                state_reg <= FAIL;
                status    <= WD_GLOBAL_TO;
            end else if (drain_to) begin
                state_reg <= FAIL;
                status    <= WD_DRAIN_TO;
            end else if ((state_reg == RUN) && one_done) begin
                state_reg <= DRAIN;
            end
        end
    end

endmodule

// File: tb/tb_retire_watchdog.sv
// Directed bench for retire_watchdog: timeouts, drain handling, priority,
// dump window and mid-run reset.
module tb_retire_watchdog;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] cfg_timeout;
    logic [63:0] cfg_global_timeout;
    logic [63:0] cfg_dump_start;
    logic [63:0] cfg_dump_end;
    logic        retire_valid;
    logic        dpi_done;
    logic        tb_done;

    logic [7:0]  status_a, status_b;
    logic [63:0] cycle_a, cycle_b;
    logic        dump_a, dump_b;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    retire_watchdog u_dut (
        .clock(clock), .reset(reset),
        .cfg_timeout(cfg_timeout), .cfg_global_timeout(cfg_global_timeout),
        .cfg_dump_start(cfg_dump_start), .cfg_dump_end(cfg_dump_end),
        .retire_valid(retire_valid), .dpi_done(dpi_done), .tb_done(tb_done),
        .status(status_a), .cycle(cycle_a), .dump_active(dump_a)
    );

    retire_watchdog #(.DRAIN_CYCLES(16)) u_dut16 (
        .clock(clock), .reset(reset),
        .cfg_timeout(cfg_timeout), .cfg_global_timeout(cfg_global_timeout),
        .cfg_dump_start(cfg_dump_start), .cfg_dump_end(cfg_dump_end),
        .retire_valid(retire_valid), .dpi_done(dpi_done), .tb_done(tb_done),
        .status(status_b), .cycle(cycle_b), .dump_active(dump_b)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hold reset for two edges with the given config, then release; cycle 0 follows.
    task automatic apply_reset(input logic [63:0] to, input logic [63:0] gto,
                               input logic [63:0] ds, input logic [63:0] de);
        reset = 1'b0;
        cfg_timeout = to;
        cfg_global_timeout = gto;
        cfg_dump_start = ds;
        cfg_dump_end = de;
        retire_valid = 1'b0;
        dpi_done = 1'b0;
        tb_done = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(64'd0, 64'd0, 64'd0, 64'd0);
        checks++;
        if (status_a !== 8'd0) begin
            failures++;
            $display("FAIL reset_status got=%0d exp=0", status_a);
        end
        checks++;
        if (cycle_a !== 64'd0) begin
            failures++;
            $display("FAIL reset_cycle got=%0d exp=0", cycle_a);
        end
        checks++;
        if (dump_a !== 1'b1 || dump_b !== 1'b1) begin
            failures++;
            $display("FAIL reset_dump got=%0b/%0b exp=1", dump_a, dump_b);
        end
        checks++;
        if (status_b !== 8'd0 || cycle_b !== 64'd0) begin
            failures++;
            $display("FAIL reset_dut16 status=%0d cycle=%0d exp=0/0", status_b, cycle_b);
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_retire_timeout();
        apply_reset(64'd4, 64'd0, 64'd100, 64'd0);
        for (int c = 0; c <= 10; c++) begin
            checks++;
            if (status_a !== ((c >= 7) ? 8'd1 : 8'd0)) begin
                failures++;
                $display("FAIL retire_to_status c=%0d got=%0d exp=%0d", c, status_a, (c >= 7) ? 1 : 0);
            end
            checks++;
            if (cycle_a !== 64'((c < 7) ? c : 7)) begin
                failures++;
                $display("FAIL retire_to_cycle c=%0d got=%0d exp=%0d", c, cycle_a, (c < 7) ? c : 7);
            end
            retire_valid = (c <= 2);
            step();
        end
        retire_valid = 1'b0;
        $display("test_retire_timeout done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_global_timeout();
        apply_reset(64'd0, 64'd10, 64'd100, 64'd0);
        // Config changes after release must have no effect.
        cfg_timeout = 64'd2;
        cfg_global_timeout = 64'd3;
        for (int c = 0; c <= 30; c++) begin
            checks++;
            if (status_a !== ((c >= 10) ? 8'd2 : 8'd0)) begin
                failures++;
                $display("FAIL global_to_status c=%0d got=%0d exp=%0d", c, status_a, (c >= 10) ? 2 : 0);
            end
            checks++;
            if (cycle_a !== 64'((c < 10) ? c : 10)) begin
                failures++;
                $display("FAIL global_to_cycle c=%0d got=%0d exp=%0d", c, cycle_a, (c < 10) ? c : 10);
            end
            step();
        end
        $display("test_global_timeout done checks=%0d failures=%0d", checks, failures);
    endtask

    // pulse=1: flags are single-cycle pulses, so the first one drops in DRAIN.
    task automatic test_drain_done(input bit pulse);
        apply_reset(64'd0, 64'd0, 64'd100, 64'd0);
        for (int c = 0; c <= 12; c++) begin
            checks++;
            if (status_a !== ((c >= 9) ? 8'd255 : 8'd0)) begin
                failures++;
                $display("FAIL drain_done_status pulse=%0d c=%0d got=%0d exp=%0d", pulse, c, status_a, (c >= 9) ? 255 : 0);
            end
            checks++;
            if (cycle_a !== 64'((c < 9) ? c : 9)) begin
                failures++;
                $display("FAIL drain_done_cycle pulse=%0d c=%0d got=%0d exp=%0d", pulse, c, cycle_a, (c < 9) ? c : 9);
            end
            dpi_done = pulse ? (c == 5) : (c >= 5);
            tb_done  = pulse ? (c == 8) : (c >= 8);
            step();
        end
        dpi_done = 1'b0;
        tb_done = 1'b0;
        $display("test_drain_done pulse=%0d done checks=%0d failures=%0d", pulse, checks, failures);
    endtask

    task automatic test_drain_timeout();
        apply_reset(64'd0, 64'd0, 64'd100, 64'd0);
        for (int c = 0; c <= 24; c++) begin
            checks++;
            if (status_b !== ((c >= 20) ? 8'd3 : 8'd0)) begin
                failures++;
                $display("FAIL drain_to_status c=%0d got=%0d exp=%0d", c, status_b, (c >= 20) ? 3 : 0);
            end
            checks++;
            if (cycle_b !== 64'((c < 20) ? c : 20)) begin
                failures++;
                $display("FAIL drain_to_cycle c=%0d got=%0d exp=%0d", c, cycle_b, (c < 20) ? c : 20);
            end
            checks++;
            if (status_a !== 8'd0) begin
                failures++;
                $display("FAIL drain_long_status c=%0d got=%0d exp=0", c, status_a);
            end
            tb_done = (c == 3);
            step();
        end
        tb_done = 1'b0;
        $display("test_drain_timeout done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_simultaneous();
        apply_reset(64'd6, 64'd6, 64'd0, 64'd0);
        for (int c = 0; c <= 8; c++) begin
            checks++;
            if (status_a !== ((c >= 6) ? 8'd255 : 8'd0)) begin
                failures++;
                $display("FAIL simul_status c=%0d got=%0d exp=%0d", c, status_a, (c >= 6) ? 255 : 0);
            end
            checks++;
            if (cycle_a !== 64'((c < 6) ? c : 6)) begin
                failures++;
                $display("FAIL simul_cycle c=%0d got=%0d exp=%0d", c, cycle_a, (c < 6) ? c : 6);
            end
            dpi_done = (c == 5);
            tb_done  = (c == 5);
            step();
        end
        dpi_done = 1'b0;
        tb_done = 1'b0;
        // Reset out of DONE.
        reset = 1'b0;
        step();
        checks++;
        if (status_a !== 8'd0 || cycle_a !== 64'd0 || dump_a !== 1'b1) begin
            failures++;
            $display("FAIL done_reset status=%0d cycle=%0d dump=%0b exp=0/0/1", status_a, cycle_a, dump_a);
        end
        $display("test_simultaneous done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_dump_window();
        apply_reset(64'd0, 64'd10, 64'd3, 64'd6);
        for (int c = 0; c <= 12; c++) begin
            checks++;
            if (dump_a !== ((c >= 3) && (c <= 5))) begin
                failures++;
                $display("FAIL dump_window c=%0d got=%0b exp=%0b", c, dump_a, (c >= 3) && (c <= 5));
            end
            checks++;
            if (status_a !== ((c >= 10) ? 8'd2 : 8'd0)) begin
                failures++;
                $display("FAIL dump_status c=%0d got=%0d exp=%0d", c, status_a, (c >= 10) ? 2 : 0);
            end
            if (c == 12) reset = 1'b0;
            step();
        end
        checks++;
        if (status_a !== 8'd0 || cycle_a !== 64'd0 || dump_a !== 1'b0) begin
            failures++;
            $display("FAIL fail_reset status=%0d cycle=%0d dump=%0b exp=0/0/0", status_a, cycle_a, dump_a);
        end
        // Inverted window (end <= start) never opens.
        apply_reset(64'd0, 64'd0, 64'd5, 64'd3);
        for (int c = 0; c <= 8; c++) begin
            checks++;
            if (dump_a !== 1'b0) begin
                failures++;
                $display("FAIL dump_inverted c=%0d got=%0b exp=0", c, dump_a);
            end
            step();
        end
        $display("test_dump_window done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        reset = 1'b0;
        cfg_timeout = '0;
        cfg_global_timeout = '0;
        cfg_dump_start = '0;
        cfg_dump_end = '0;
        retire_valid = 1'b0;
        dpi_done = 1'b0;
        tb_done = 1'b0;
        test_reset();
        test_retire_timeout();
        test_global_timeout();
        test_drain_done(1'b0);
        test_drain_done(1'b1);
        test_drain_timeout();
        test_simultaneous();
        test_dump_window();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/retire_watchdog.md
Name: retire_watchdog

Overview:
- Synthesizable cycle monitor directly downstream of the testbench clock/reset generator; consumes its clock and reset (reset inverted by harness to active-low).
- Watches vector-instruction retire events and the two completion flags (DPI side, testbench side) and produces one status byte for the clock generator's per-cycle poll.
- Also produces the waveform-dump window enable.
- Moves the timeout and dump-window logic from behavioural loops into clocked RTL.

Parameters:
- CNT_W, 64, width of the cycle, idle and drain counters and of the timeout/dump config inputs.
- DRAIN_CYCLES, 1024, max cycles allowed between the first and the second completion flag.

Ports:
- clock  input  1  sole clock.
- reset  input  1  synchronous, active-low reset.
- cfg_timeout  input  CNT_W  max consecutive cycles without retire; 0 = disabled.
- cfg_global_timeout  input  CNT_W  max total cycles; 0 = disabled.
- cfg_dump_start  input  CNT_W  first cycle of the dump window.
- cfg_dump_end  input  CNT_W  first cycle after the dump window; 0 = open-ended.
- retire_valid  input  1  one or more vector instructions retire this cycle.
- dpi_done  input  1  level; DPI side finished.
- tb_done  input  1  level; testbench finished.
- status  output  8  0 = running, 255 = success, 1 = retire timeout, 2 = global timeout, 3 = drain timeout.
- cycle  output  CNT_W  cycles elapsed since reset release.
- dump_active  output  1  waveform dump enabled.

Behaviour:
Reset and configuration
- Reset (reset==0 at posedge) forces: state=RUN, status=0, cycle=0, idle_cnt=0, drain_cnt=0, dump_active=(cfg_dump_start==0).
- All cfg_* are captured every reset cycle.
- cfg_* are ignored while reset is deasserted; captured values are held until the next reset.
- Reset mid-operation, including from DONE or FAIL, returns the block to the reset state on the same edge.

Counters
- cycle increments by 1 each clock in RUN and DRAIN.
- cycle saturates at all-ones and freezes in DONE and FAIL.
- idle_cnt clears on any cycle with retire_valid=1; otherwise it increments, saturating.

FSM: RUN, DRAIN, DONE, FAIL. DONE and FAIL are sticky until reset.
- RUN -> DONE when dpi_done & tb_done in the same cycle.
- RUN -> DRAIN when exactly one of dpi_done / tb_done is 1; drain_cnt cleared.
- DRAIN -> DONE when both flags are 1.
- DRAIN: drain_cnt increments each cycle; DRAIN -> FAIL(3) when drain_cnt+1 == DRAIN_CYCLES.
- A completion flag dropping in DRAIN is ignored; each flag is latched sticky once seen.
- Any non-terminal state -> FAIL(1) when cfg_timeout!=0 and idle_cnt+1 == cfg_timeout with retire_valid=0.
  - Example: timeout T fires on the T-th consecutive idle cycle.
- Any non-terminal state -> FAIL(2) when cfg_global_timeout!=0 and cycle+1 == cfg_global_timeout.

Priority and timing
- Priority on the same cycle: DONE > code 1 > code 2 > code 3.
- status is registered: it updates on the edge that enters DONE (255) or FAIL (code) and holds thereafter.
- In RUN and DRAIN, status=0.
- Latency: event cycle -> status visible the cycle after the edge.

Dump window
- dump_active is registered, computed from the next value of cycle:
  - dump_active = (cycle_next >= start) && (end==0 || cycle_next < end).
- If end != 0 and end <= start, dump_active stays 0.
- dump_active holds its value in DONE and FAIL.

Decomposition:
- Shared package t1emu_sim_pkg holds:
  - enum wd_state_e {RUN, DRAIN, DONE, FAIL};
  - status byte constants WD_RUNNING=8'd0, WD_SUCCESS=8'd255, WD_RETIRE_TO=8'd1, WD_GLOBAL_TO=8'd2, WD_DRAIN_TO=8'd3.
- One natural sub-module: sat_counter (width param, clear, enable, saturate), instantiated for cycle, idle and drain counters.

Test Plan:
- timeout=4, global=0; retire_valid pulses at cycles 0..2 after reset release, then idle -> status=1 from cycle 7; cycle frozen at 7.
- timeout=0, global=10, no retires -> status=2 from cycle 10; status stays 2 through 20 further cycles.
- dpi_done=1 at cycle 5, tb_done=1 at cycle 8, DRAIN_CYCLES=1024, timeout=0 -> status 0 through cycle 8, 255 from cycle 9.
- tb_done=1 only at cycle 3, DRAIN_CYCLES=16 -> status=3 from cycle 20.
- Simultaneous: timeout=6, global=6, no retires, both done flags asserted at cycle 5 -> status=255 (done beats both timeouts).
- dump_start=3, dump_end=6: dump_active=1 exactly for cycle values 3..5; then reset asserted at cycle 12 in FAIL -> all outputs return to reset values on that edge.
